// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words on a valid/ready
// handshake and shifts them out one bit per clock, idling the line at 0.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load_valid,
  input  logic [WIDTH-1:0]         load_data,
  output logic                     load_ready,
  output logic                     serial_out,
  output logic                     serial_valid,
  output logic                     word_done,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    count_q, count_d;
  logic             accept;

  // Handshake: a word transfers on any rising edge where load_valid and
  // load_ready are both high; load_ready never depends on load_valid, and
  // the sender must hold load_valid/load_data stable until that edge.
  assign accept = load_valid && load_ready;

  // All outputs decode from registered state only.
  assign serial_valid = (state_q == SHIFT);
  assign word_done    = (state_q == SHIFT) && (count_q == '0);
  assign load_ready   = (state_q == IDLE) || word_done;
  assign serial_out   = serial_valid ? (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]) : 1'b0;
  assign bit_count    = count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          sreg_d  = load_data;
          count_d = LAST_CNT;
        end
      end
      SHIFT: begin
        if (count_q != '0) begin
          sreg_d  = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
          count_d = count_q - 1'b1;
        end else if (accept) begin
          // Reload on the last bit keeps the stream contiguous.
          sreg_d  = load_data;
          count_d = LAST_CNT;
        end else begin
          state_d = IDLE;
          sreg_d  = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        sreg_d  = '0;
        count_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: one MSB-first and one LSB-first instance,
// each scenario checked cycle by cycle against hand-computed bit streams.
module tb_bit_serializer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic       lv_m = 1'b0;
  logic [7:0] ld_m = 8'h00;
  logic       rdy_m, so_m, sv_m, wd_m;
  logic [2:0] bc_m;

  logic       lv_l = 1'b0;
  logic [7:0] ld_l = 8'h00;
  logic       rdy_l, so_l, sv_l, wd_l;
  logic [2:0] bc_l;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clock        (clock),
    .reset        (reset),
    .load_valid   (lv_m),
    .load_data    (ld_m),
    .load_ready   (rdy_m),
    .serial_out   (so_m),
    .serial_valid (sv_m),
    .word_done    (wd_m),
    .bit_count    (bc_m)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clock        (clock),
    .reset        (reset),
    .load_valid   (lv_l),
    .load_data    (ld_l),
    .load_ready   (rdy_l),
    .serial_out   (so_l),
    .serial_valid (sv_l),
    .word_done    (wd_l),
    .bit_count    (bc_l)
  );

  // Observed vectors are {serial_valid, serial_out, word_done, load_ready, bit_count}.
  task automatic test_reset();
    logic [6:0] exp;
    logic [6:0] obs;
    #1;
    exp = 7'b000_1_000;
    obs = {sv_m, so_m, wd_m, rdy_m, bc_m};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_msb: got %b expected %b", obs, exp); end
    obs = {sv_l, so_l, wd_l, rdy_l, bc_l};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_lsb: got %b expected %b", obs, exp); end
    @(negedge clock);
    reset = 1'b0;

    // Start 8'hFF, let three bits out, then reset between edges.
    @(negedge clock);
    lv_m = 1'b1; ld_m = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      lv_m = 1'b0;
      exp = {1'b1, 1'b1, 1'b0, 1'b0, 3'(7 - i)};
      obs = {sv_m, so_m, wd_m, rdy_m, bc_m};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_pre_bit cycle %0d: got %b expected %b", i, obs, exp); end
    end
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    exp = 7'b000_1_000;
    obs = {sv_m, so_m, wd_m, rdy_m, bc_m};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_async: got %b expected %b", obs, exp); end

    // load_valid during reset must not be accepted.
    lv_m = 1'b1; ld_m = 8'hFF;
    @(negedge clock);
    @(negedge clock);
    obs = {sv_m, so_m, wd_m, rdy_m, bc_m};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_no_accept: got %b expected %b", obs, exp); end
    lv_m = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    obs = {sv_m, so_m, wd_m, rdy_m, bc_m};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_release_idle: got %b expected %b", obs, exp); end

    // Fresh word 8'h00: nothing from 8'hFF may remain.
    lv_m = 1'b1; ld_m = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      lv_m = 1'b0;
      exp = {1'b1, 1'b0, (i == 7), (i == 7), 3'(7 - i)};
      obs = {sv_m, so_m, wd_m, rdy_m, bc_m};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_zero_word cycle %0d: got %b expected %b", i, obs, exp); end
    end
    @(negedge clock);
    exp = 7'b000_1_000;
    obs = {sv_m, so_m, wd_m, rdy_m, bc_m};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_zero_tail: got %b expected %b", obs, exp); end
  endtask

  task automatic test_single();
    logic [7:0] w;
    logic [6:0] exp;
    logic [6:0] obs;
    w = 8'hA5;
    @(negedge clock);
    lv_m = 1'b1; ld_m = w;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      lv_m = 1'b0; ld_m = 8'h00;
      exp = {1'b1, w[7 - i], (i == 7), (i == 7), 3'(7 - i)};
      obs = {sv_m, so_m, wd_m, rdy_m, bc_m};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL single_a5 cycle %0d: got %b expected %b", i, obs, exp); end
    end
    @(negedge clock);
    exp = 7'b000_1_000;
    obs = {sv_m, so_m, wd_m, rdy_m, bc_m};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL single_tail: got %b expected %b", obs, exp); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    logic       wd;
    logic [6:0] exp;
    logic [6:0] obs;
    @(negedge clock);
    checks++;
    if (rdy_m !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle: got %b expected 1", rdy_m); end
    lv_m = 1'b1; ld_m = 8'hA5;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (i == 0) ld_m = 8'h5A;
      if (i == 8) lv_m = 1'b0;
      w  = (i < 8) ? 8'hA5 : 8'h5A;
      wd = (i == 7) || (i == 15);
      exp = {1'b1, w[7 - (i % 8)], wd, wd, 3'(7 - (i % 8))};
      obs = {sv_m, so_m, wd_m, rdy_m, bc_m};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL b2b cycle %0d: got %b expected %b", i, obs, exp); end
    end
    @(negedge clock);
    exp = 7'b000_1_000;
    obs = {sv_m, so_m, wd_m, rdy_m, bc_m};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL b2b_tail: got %b expected %b", obs, exp); end
  endtask

  task automatic test_stall();
    logic [7:0] w;
    logic       wd;
    logic [6:0] exp;
    logic [6:0] obs;
    @(negedge clock);
    lv_m = 1'b1; ld_m = 8'hA5;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (i == 0) lv_m = 1'b0;
      if (i == 4) begin lv_m = 1'b1; ld_m = 8'h3C; end
      if (i == 8) lv_m = 1'b0;
      w  = (i < 8) ? 8'hA5 : 8'h3C;
      wd = (i == 7) || (i == 15);
      exp = {1'b1, w[7 - (i % 8)], wd, wd, 3'(7 - (i % 8))};
      obs = {sv_m, so_m, wd_m, rdy_m, bc_m};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL stall cycle %0d: got %b expected %b", i, obs, exp); end
    end
    @(negedge clock);
    exp = 7'b000_1_000;
    obs = {sv_m, so_m, wd_m, rdy_m, bc_m};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL stall_tail: got %b expected %b", obs, exp); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] words [2];
    logic [7:0] w;
    logic [6:0] exp;
    logic [6:0] obs;
    words[0] = 8'h01;
    words[1] = 8'h80;
    for (int k = 0; k < 2; k++) begin
      w = words[k];
      @(negedge clock);
      lv_l = 1'b1; ld_l = w;
      for (int i = 0; i < 8; i++) begin
        @(negedge clock);
        lv_l = 1'b0;
        exp = {1'b1, w[i], (i == 7), (i == 7), 3'(7 - i)};
        obs = {sv_l, so_l, wd_l, rdy_l, bc_l};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL lsb_word%0d cycle %0d: got %b expected %b", k, i, obs, exp); end
      end
      @(negedge clock);
      exp = 7'b000_1_000;
      obs = {sv_l, so_l, wd_l, rdy_l, bc_l};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL lsb_tail%0d: got %b expected %b", k, obs, exp); end
    end
  endtask

  // Overlapping "101" detector fed from serial_out, including idle cycles.
  task automatic test_detector_chain();
    logic [2:0] hist;
    int         pulses;
    int         idx1;
    int         idx2;
    hist = 3'b000; pulses = 0; idx1 = -1; idx2 = -1;
    @(negedge clock);
    lv_m = 1'b1; ld_m = 8'b1010_1000;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      lv_m = 1'b0;
      checks++;
      if (sv_m !== (i < 8)) begin errors++; $display("FAIL chain_valid cycle %0d: got %b expected %b", i, sv_m, (i < 8)); end
      hist = {hist[1:0], so_m};
      if (hist == 3'b101) begin
        pulses++;
        if (idx1 < 0) idx1 = i; else idx2 = i;
      end
    end
    checks++;
    if (pulses !== 2) begin errors++; $display("FAIL chain_pulses: got %0d expected 2", pulses); end
    checks++;
    if (idx1 !== 2) begin errors++; $display("FAIL chain_first_idx: got %0d expected 2", idx1); end
    checks++;
    if (idx2 !== 4) begin errors++; $display("FAIL chain_second_idx: got %0d expected 4", idx2); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_lsb_first();
    test_detector_chain();
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
